// File: rtl/ac_sequencer.sv
// Accumulator command sequencer: takes one AC command over valid/ready, drives
// the AC load/clear strobes and reports done plus Z/C flags. Optional macro AC_SEQ_SATURATE_EN.
module ac_sequencer #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] ac_out,
  output logic [WIDTH-1:0] ac_in,
  output logic             ac_re,
  output logic             ac_clear,
  output logic             busy,
  output logic             done,
  output logic             flag_z,
  output logic             flag_c
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and the requester holds the command stable until then.

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_CLR = 3'd1;
  localparam logic [2:0] OP_LD  = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] cnt_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;

  // Top bit of the widened sum is the carry; of the difference, the borrow.
  assign sum  = {1'b0, ac_out} + {1'b0, data_q};
  assign diff = {1'b0, ac_out} - {1'b0, data_q};

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // AC write data follows the live AC value so consecutive shift writes chain.
  always_comb begin
    ac_in    = '0;
    ac_re    = 1'b0;
    ac_clear = 1'b0;
    case (state)
      EXEC: begin
        case (op_q)
          OP_CLR: ac_clear = 1'b1;
          OP_LD: begin
            ac_re = 1'b1;
            ac_in = data_q;
          end
          OP_ADD: begin
            ac_re = 1'b1;
`ifdef AC_SEQ_SATURATE_EN
            ac_in = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
            ac_in = sum[WIDTH-1:0];
`endif
          end
          OP_SUB: begin
            ac_re = 1'b1;
`ifdef AC_SEQ_SATURATE_EN
            ac_in = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
            ac_in = diff[WIDTH-1:0];
`endif
          end
          OP_AND: begin
            ac_re = 1'b1;
            ac_in = ac_out & data_q;
          end
          default: ;
        endcase
      end
      SHIFT: begin
        ac_re = 1'b1;
        ac_in = (op_q == OP_SHL) ? {ac_out[WIDTH-2:0], 1'b0} : {1'b0, ac_out[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_NOP;
      data_q <= '0;
      cnt_q  <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            cnt_q  <= cmd_data[SHAMT_W-1:0];
            case (cmd_op)
              OP_NOP: state <= DONE;
              OP_SHL, OP_SHR:
                state <= (cmd_data[SHAMT_W-1:0] == '0) ? DONE : SHIFT;
              default: state <= EXEC;
            endcase
          end
        end
        EXEC: begin
          if (op_q == OP_ADD) flag_c <= sum[WIDTH];
          if (op_q == OP_SUB) flag_c <= diff[WIDTH];
          state <= DONE;
        end
        SHIFT: begin
          flag_c <= (op_q == OP_SHL) ? ac_out[WIDTH-1] : ac_out[0];
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == SHAMT_W'(1)) state <= DONE;
        end
        DONE: begin
          flag_z <= (ac_out == '0);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac_sequencer.sv
// Directed bench for ac_sequencer: a behavioural AC register closes the loop,
// and each step checks latency, write counts, AC contents and flags.
module tb_ac_sequencer;

  localparam int W = 16;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_CLR = 3'd1;
  localparam logic [2:0] OP_LD  = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'd0;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] ac = '0;
  logic [W-1:0] ac_in;
  logic         ac_re;
  logic         ac_clear;
  logic         busy;
  logic         done;
  logic         flag_z;
  logic         flag_c;

  int checks = 0;
  int failures = 0;
  int re_cnt = 0;
  int clr_cnt = 0;

  ac_sequencer #(.WIDTH(W), .SHAMT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .ac_out(ac), .ac_in(ac_in), .ac_re(ac_re), .ac_clear(ac_clear),
    .busy(busy), .done(done), .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  // The AC register the sequencer owns, plus strobe counters.
  always @(posedge clk) begin
    if (ac_clear) ac <= '0;
    else if (ac_re) ac <= ac_in;
    if (ac_re) re_cnt <= re_cnt + 1;
    if (ac_clear) clr_cnt <= clr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the acceptance edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] data);
    int n;
    cmd_op = op;
    cmd_data = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done_seen"}, done, 1);
  endtask

  // Full command: latency and write count, then steps into the following IDLE cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] data,
                        input int exp_lat, input int exp_re);
    int r0;
    int lat;
    r0 = re_cnt;
    issue(op, data);
    wait_done(tag, lat);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_re_count"}, re_cnt - r0, exp_re);
    @(negedge clk);
    chk({tag, "_ready_after"}, cmd_ready, 1);
  endtask

  initial begin
    int lat;
    int r0;
    int c0;
    int n;

    // Reset state
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re", ac_re, 0);
    chk("rst_clear", ac_clear, 0);
    chk("rst_ac_in", ac_in, 0);
    chk("rst_flag_z", flag_z, 0);
    chk("rst_flag_c", flag_c, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // LD 0x00FF: EXEC cycle drives the write
    issue(OP_LD, 16'h00FF);
    chk("ld_exec_re", ac_re, 1);
    chk("ld_exec_ac_in", ac_in, 16'h00FF);
    chk("ld_exec_busy", busy, 1);
    chk("ld_exec_ready", cmd_ready, 0);
    wait_done("ld", lat);
    chk("ld_latency", lat, 1);
    @(negedge clk);
    chk("ld_ac", ac, 16'h00FF);
    chk("ld_flag_z", flag_z, 0);

    // ADD 0xFF01 carries out of 16 bits
    run_op("add", OP_ADD, 16'hFF01, 1, 1);
    chk("add_flag_c", flag_c, 1);
`ifdef AC_SEQ_SATURATE_EN
    chk("add_ac", ac, 16'hFFFF);
    chk("add_flag_z", flag_z, 0);
`else
    chk("add_ac", ac, 16'h0000);
    chk("add_flag_z", flag_z, 1);
`endif

    // 5 - 7 borrows
    run_op("ld5", OP_LD, 16'h0005, 1, 1);
    run_op("sub", OP_SUB, 16'h0007, 1, 1);
    chk("sub_flag_c", flag_c, 1);
`ifdef AC_SEQ_SATURATE_EN
    chk("sub_ac", ac, 16'h0000);
    chk("sub_flag_z", flag_z, 1);
`else
    chk("sub_ac", ac, 16'hFFFE);
    chk("sub_flag_z", flag_z, 0);
`endif

    // SHL 3 on 0x8001: bit 15 out first, last out is original bit 13
    run_op("ld8001", OP_LD, 16'h8001, 1, 1);
    chk("ld8001_flag_c_kept", flag_c, 1);
    run_op("shl3", OP_SHL, 16'h0003, 3, 3);
    chk("shl3_ac", ac, 16'h0008);
    chk("shl3_flag_c", flag_c, 0);
    chk("shl3_flag_z", flag_z, 0);
    run_op("shr0_a", OP_SHR, 16'h0000, 0, 0);
    chk("shr0_a_ac", ac, 16'h0008);
    chk("shr0_a_flag_c", flag_c, 0);

    // SHR 1 on 0x0001 sets carry; count 0 must leave it set
    run_op("ld1", OP_LD, 16'h0001, 1, 1);
    run_op("shr1", OP_SHR, 16'h0001, 1, 1);
    chk("shr1_ac", ac, 16'h0000);
    chk("shr1_flag_c", flag_c, 1);
    chk("shr1_flag_z", flag_z, 1);
    run_op("shr0_b", OP_SHR, 16'h0010, 0, 0);
    chk("shr0_b_flag_c", flag_c, 1);
    run_op("nop", OP_NOP, 16'hABCD, 0, 0);
    chk("nop_ac", ac, 16'h0000);

    // CLR with a second command held while busy
    run_op("ld1234", OP_LD, 16'h1234, 1, 1);
    chk("ld1234_flag_z", flag_z, 0);
    c0 = clr_cnt;
    r0 = re_cnt;
    issue(OP_CLR, 16'h0000);
    chk("clr_exec_clear", ac_clear, 1);
    chk("clr_exec_re", ac_re, 0);
    cmd_op = OP_LD;
    cmd_data = 16'h00AA;
    cmd_valid = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      chk("held_ready_low", cmd_ready, 0);
      @(negedge clk);
      n++;
    end
    chk("clr_done_seen", done, 1);
    chk("held_ready_at_done", cmd_ready, 0);
    chk("clr_latency", n, 1);
    chk("clr_clear_count", clr_cnt - c0, 1);
    chk("clr_re_count", re_cnt - r0, 0);
    @(negedge clk);
    chk("clr_ac", ac, 16'h0000);
    chk("clr_flag_z", flag_z, 1);
    chk("clr_flag_c_kept", flag_c, 1);
    chk("held_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("held_exec_ac_in", ac_in, 16'h00AA);
    wait_done("held", lat);
    chk("held_latency", lat, 1);
    @(negedge clk);
    chk("held_ac", ac, 16'h00AA);

    // AND leaves flag_c alone
    run_op("ldffff", OP_LD, 16'hFFFF, 1, 1);
    run_op("and", OP_AND, 16'h0F0F, 1, 1);
    chk("and_ac", ac, 16'h0F0F);
    chk("and_flag_c", flag_c, 1);
    chk("and_flag_z", flag_z, 0);

    // Reset during SHL 8 after three shifts
    run_op("ldffff2", OP_LD, 16'hFFFF, 1, 1);
    r0 = re_cnt;
    issue(OP_SHL, 16'h0008);
    repeat (3) @(negedge clk);
    chk("mid_re_count", re_cnt - r0, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_re", ac_re, 0);
    chk("mid_rst_clear", ac_clear, 0);
    chk("mid_rst_ac_in", ac_in, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_flag_c", flag_c, 0);
    chk("mid_rst_flag_z", flag_z, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_no_more_writes", re_cnt - r0, 3);
    chk("mid_ac", ac, 16'hFFF8);
    chk("mid_ready_after", cmd_ready, 1);
    chk("mid_busy_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
